// File: rtl/fft1024_twiddle_lut_pkg.sv
// ---------------------------------------------------------------------------
// fft1024_pkg
// Shared constants and types for the 1024-point radix-2 FFT core.
//   N        : transform length (1024 only)
//   LOG2N    : width of the twiddle / sample index
//   TW_W     : width of one signed twiddle component (16 only)
//   TW_SCALE : integer magnitude that represents +/-1.0
//   twiddle_t: packed {re, im} pair, re in the upper half of the word
// ---------------------------------------------------------------------------
package fft1024_pkg;

    localparam int N        = 1024;
    localparam int LOG2N    = 10;
    localparam int TW_W     = 16;
    localparam int TW_SCALE = 32767;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } twiddle_t;

endpackage

// File: rtl/fft1024_twiddle_lut_if.sv
// ---------------------------------------------------------------------------
// fft1024_twiddle_lut_if
// Lookup bus between the FFT address generator and the twiddle ROM.
//   en      : output-register load enable (ignored in combinational build)
//   n       : twiddle index 0..1023
//   twiddle : {re[31:16], im[15:0]}, both signed two's complement
// Modports: master drives en/n and reads twiddle; slave is the ROM side.
// ---------------------------------------------------------------------------
interface fft1024_twiddle_lut_if;
    import fft1024_pkg::*;

    logic             en;
    logic [LOG2N-1:0] n;
    logic [31:0]      twiddle;

    modport master (
        output en,
        output n,
        input  twiddle
    );

    modport slave (
        input  en,
        input  n,
        output twiddle
    );

endinterface

// File: rtl/fft1024_twiddle_lut_quarter_sin_rom.sv
// ---------------------------------------------------------------------------
// fft1024_quarter_sin_rom
// Combinational quarter-wave sine table:
//   q[m] = round(32767 * sin(2*pi*m/1024)),  m = 0..256  (257 entries)
// Every entry is non-negative and fits in 15 bits; q[256] = 32767.
// Ports:
//   m : 9-bit table address; addresses above 256 read as zero
//   q : 15-bit unsigned magnitude
// The table contents are fixed at elaboration time by a constant function,
// so the result is a plain constant ROM with no run-time arithmetic.
// ---------------------------------------------------------------------------
module fft1024_quarter_sin_rom
    import fft1024_pkg::*;
(
    input  logic [8:0]  m,
    output logic [14:0] q
);

    localparam real PI = 3.14159265358979323846;

    // Taylor series for sin over [0, pi/2]; twenty terms are far beyond
    // double precision there.  Values are non-negative, so adding one half
    // and truncating is round-half-away-from-zero.
    function automatic logic [14:0] quarter_sin(input int idx);
        real x;
        real term;
        real sum;
        real scaled;
        int  val;
        x    = 2.0 * PI * real'(idx) / 1024.0;
        term = x;
        sum  = x;
        for (int k = 1; k < 20; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        scaled = 32767.0 * sum + 0.5;
        val    = $rtoi(scaled);
        if (val > 32767) begin
            val = 32767;
        end
        if (val < 0) begin
            val = 0;
        end
        return 15'(val);
    endfunction

    logic [14:0] rom [257];

    for (genvar i = 0; i < 257; i++) begin : g_rom
        localparam logic [14:0] ENTRY = quarter_sin(i);
        assign rom[i] = ENTRY;
    end

    // Only 0..256 are populated; the top never issues anything else, but
    // the remaining 9-bit codes still return a defined value.
    always_comb begin
        q = '0;
        if (m <= 9'd256) begin
            q = rom[m];
        end
    end

endmodule

// File: rtl/fft1024_twiddle_lut.sv
// ---------------------------------------------------------------------------
// fft1024_twiddle_lut
// Twiddle-factor ROM for the 1024-point radix-2 DIT FFT core:
//   twiddle = W_1024^n = {round(32767*cos(2*pi*n/1024)),
//                         round(-32767*sin(2*pi*n/1024))}
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, clears the output register
//   bus   : fft1024_twiddle_lut_if.slave (en, n in; twiddle out)
// Build option FFT1024_TWIDDLE_COMB_EN: when defined, twiddle is a purely
// combinational function of n and clk/reset/en are ignored; otherwise the
// result is registered with one cycle of latency and en as load enable.
// ---------------------------------------------------------------------------
module fft1024_twiddle_lut
    import fft1024_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    fft1024_twiddle_lut_if.slave        bus
);

    logic [1:0]        quad;
    logic [7:0]        r;
    logic [8:0]        m_fwd;
    logic [8:0]        m_rev;
    logic [14:0]       q_fwd;
    logic [14:0]       q_rev;
    logic signed [15:0] s_fwd;
    logic signed [15:0] s_rev;
    twiddle_t          tw_next;

    assign quad  = bus.n[9:8];
    assign r     = bus.n[7:0];

    // q[r] gives the sine within the quadrant, q[256-r] the cosine.
    // r = 0 selects q[256] = 32767, hence the 9-bit reverse address.
    assign m_fwd = {1'b0, r};
    assign m_rev = 9'd256 - {1'b0, r};

    fft1024_quarter_sin_rom u_rom_fwd (
        .m (m_fwd),
        .q (q_fwd)
    );

    fft1024_quarter_sin_rom u_rom_rev (
        .m (m_rev),
        .q (q_rev)
    );

    assign s_fwd = signed'({1'b0, q_fwd});
    assign s_rev = signed'({1'b0, q_rev});

    // Quadrant folding of cos / -sin onto the quarter-wave table.  The
    // magnitudes never exceed 32767, so 16-bit negation cannot overflow.
    always_comb begin
        tw_next = '0;
        unique case (quad)
            2'd0: begin
                tw_next.re = s_rev;
                tw_next.im = -s_fwd;
            end
            2'd1: begin
                tw_next.re = -s_fwd;
                tw_next.im = -s_rev;
            end
            2'd2: begin
                tw_next.re = -s_rev;
                tw_next.im = s_fwd;
            end
            default: begin
                tw_next.re = s_fwd;
                tw_next.im = s_rev;
            end
        endcase
    end

`ifdef FFT1024_TWIDDLE_COMB_EN

    // Zero-latency build: the clock, reset and enable have no effect.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, reset, bus.en};

    assign bus.twiddle = tw_next;

`else

    twiddle_t tw_reg;

    // Output register: reset wins over en; en low holds the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            tw_reg <= '0;
        end else if (bus.en) begin
            tw_reg <= tw_next;
        end
    end

    assign bus.twiddle = tw_reg;

`endif

endmodule

// File: tb/tb_fft1024_twiddle_lut.sv
// ---------------------------------------------------------------------------
// tb_fft1024_twiddle_lut
// Self-checking bench for fft1024_twiddle_lut.  The reference twiddle is
// computed directly from cos/sin with half-away-from-zero rounding.  The
// default build checks the registered output; with FFT1024_TWIDDLE_COMB_EN
// defined the same reference is checked combinationally.
// ---------------------------------------------------------------------------
module tb_fft1024_twiddle_lut;

    logic clk;
    logic reset;

    int check_count;
    int error_count;

    fft1024_twiddle_lut_if bus ();

    fft1024_twiddle_lut dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round half away from zero.
    function automatic int round_away(input real v);
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end
        return -$rtoi(-v + 0.5);
    endfunction

    // W_1024^idx scaled by 32767, packed as {re, im}.
    function automatic logic [31:0] ref_twiddle(input int idx);
        real ang;
        int  re;
        int  im;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / 1024.0;
        re  = round_away(32767.0 * $cos(ang));
        im  = round_away(-32767.0 * $sin(ang));
        return {re[15:0], im[15:0]};
    endfunction

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

`ifndef FFT1024_TWIDDLE_COMB_EN

    logic [31:0] model_reg;
    logic [31:0] obs [1024];
    int          order [1024];

    // Drive one cycle of inputs, advance the behavioural register across the
    // rising edge, then sample the DUT on the falling edge.
    task automatic applyStimulus(input logic rst_v, input logic en_v,
                                 input int n_v, input string tag,
                                 output logic [31:0] seen);
        reset  = rst_v;
        bus.en = en_v;
        bus.n  = 10'(n_v);
        @(posedge clk);
        if (rst_v) begin
            model_reg = 32'h0000_0000;
        end else if (en_v) begin
            model_reg = ref_twiddle(n_v);
        end
        @(negedge clk);
        seen = bus.twiddle;
        checkOutput(tag, seen, model_reg);
    endtask

    initial begin
        logic [31:0] seen;
        logic signed [15:0] re_a, im_a, re_b, im_b;
        longint mag;
        check_count = 0;
        error_count = 0;
        model_reg   = 32'h0;
        reset  = 1'b1;
        bus.en = 1'b0;
        bus.n  = '0;
        @(negedge clk);

        // Reset, then three idle cycles with en low.
        applyStimulus(1'b1, 1'b0, 0, "reset", seen);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 0, "idle", seen);
            checkOutput("idle_zero", seen, 32'h0000_0000);
        end

        // Quadrant corners and two interior points against fixed words.
        applyStimulus(1'b0, 1'b1, 0, "n0", seen);
        checkOutput("n0_const", seen, 32'h7FFF_0000);
        applyStimulus(1'b0, 1'b1, 256, "n256", seen);
        checkOutput("n256_const", seen, 32'h0000_8001);
        applyStimulus(1'b0, 1'b1, 512, "n512", seen);
        checkOutput("n512_const", seen, 32'h8001_0000);
        applyStimulus(1'b0, 1'b1, 768, "n768", seen);
        checkOutput("n768_const", seen, 32'h0000_7FFF);
        applyStimulus(1'b0, 1'b1, 1, "n1", seen);
        checkOutput("n1_const", seen, 32'h7FFE_FF37);
        applyStimulus(1'b0, 1'b1, 128, "n128", seen);
        checkOutput("n128_const", seen, 32'h5A82_A57E);

        // Full sweep of all indices in a random order.
        for (int i = 0; i < 1024; i++) begin
            order[i] = i;
        end
        for (int i = 1023; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(1'b0, 1'b1, order[i], $sformatf("sweep_n%0d", order[i]), seen);
            obs[order[i]] = seen;
        end

        // Half-turn symmetry and unit magnitude on the observed words.
        for (int i = 0; i < 512; i++) begin
            re_a = obs[i][31:16];
            im_a = obs[i][15:0];
            re_b = -re_a;
            im_b = -im_a;
            checkOutput($sformatf("sym_n%0d", i), obs[i + 512], {re_b, im_b});
        end
        for (int i = 0; i < 1024; i += 7) begin
            re_a = obs[i][31:16];
            im_a = obs[i][15:0];
            mag  = longint'(re_a) * longint'(re_a) + longint'(im_a) * longint'(im_a)
                 - 64'sd1073676289;
            if (mag < 0) begin
                mag = -mag;
            end
            checkOutput($sformatf("mag_n%0d", i), {31'd0, mag <= 64'sd65534}, 32'd1);
        end

        // Random enables, indices and occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic rst_v;
            logic en_v;
            rst_v = ($urandom_range(0, 31) == 0);
            en_v  = ($urandom_range(0, 3) != 0);
            applyStimulus(rst_v, en_v, int'($urandom_range(0, 1023)), "random", seen);
        end

        // Hold with en low while n changes, reset priority, then reload.
        applyStimulus(1'b0, 1'b1, 128, "hold_load", seen);
        applyStimulus(1'b0, 1'b0, 300, "hold", seen);
        checkOutput("hold_const", seen, 32'h5A82_A57E);
        applyStimulus(1'b1, 1'b1, 300, "reset_prio", seen);
        checkOutput("reset_prio_zero", seen, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1, "reload", seen);
        checkOutput("reload_const", seen, 32'h7FFE_FF37);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

`else

    // Combinational build: twiddle must follow n with no clock involvement.
    initial begin
        check_count = 0;
        error_count = 0;
        reset  = 1'b1;
        bus.en = 1'b0;
        bus.n  = 10'd256;
        #1;
        checkOutput("comb_n256_const", bus.twiddle, 32'h0000_8001);
        bus.n = 10'd0;
        #1;
        checkOutput("comb_n0_const", bus.twiddle, 32'h7FFF_0000);
        bus.n = 10'd128;
        #1;
        checkOutput("comb_n128_const", bus.twiddle, 32'h5A82_A57E);
        for (int i = 0; i < 1024; i++) begin
            reset  = 1'($urandom_range(0, 1));
            bus.en = 1'($urandom_range(0, 1));
            bus.n  = 10'(i);
            #3;
            checkOutput($sformatf("comb_n%0d", i), bus.twiddle, ref_twiddle(i));
        end
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

`endif

    // Hard stop if the run ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/fft1024_twiddle_lut.md
Name: fft1024_twiddle_lut

Overview:
- Twiddle-factor ROM for the 1024-point radix-2 decimation-in-time FFT core.
- Maps twiddle index n to W_1024^n = cos(2πn/1024) − j·sin(2πn/1024), with both parts scaled by 32767.
- Output is one 32-bit word, {re, im}.
- The FFT datapath multiplies the bottom butterfly input by this word and shifts right by 15.

Parameters:
- N, 1024, transform length; only 1024 is supported.
- TW_W, 16, width of each twiddle component (signed); only 16 is supported.
- SCALE, 32767, full-scale magnitude of ±1.0.

Ports:
- Clk  input  1  system clock; all state is updated on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  output-register load enable.
- n  input  10  twiddle index, 0..1023.
- twiddle  output  32  {twiddle_re[31:16], twiddle_im[15:0]}; both parts are signed two's complement.

Behaviour:
- Reset (synchronous, active-high): twiddle <= 32'h0000_0000. Reset takes priority over En.
- Latency: 1 cycle. If En=1 at edge t, twiddle shows the entry for the n sampled at edge t. If En=0, twiddle holds its value.
- Value definition:
  - twiddle_re = round(32767·cos(2πn/1024)).
  - twiddle_im = round(−32767·sin(2πn/1024)).
  - Rounding is half away from zero.
  - Range is ±32767. −32768 never appears.
- Storage is a quarter-wave table q[m] = round(32767·sin(2πm/1024)), m = 0..256, 257 entries of 15-bit unsigned values, widened to 16-bit signed.
- Quadrant decode: Q = n[9:8], r = n[7:0].
  - Q=0: re = q[256−r], im = −q[r]
  - Q=1: re = −q[r], im = −q[256−r]
  - Q=2: re = −q[256−r], im = q[r]
  - Q=3: re = q[r], im = q[256−r]
- Negation is 16-bit two's complement. The index 256−r is 9 bits; r=0 selects q[256]=32767.
- All 1024 indices are valid; there are no out-of-range values. The FFT core only issues n ≤ 511, but 512..1023 must still be correct.
- Symmetry property: W^(n+512) = −W^n in both parts.
- A change of n without En has no effect on the output.
- Reset mid-stream clears the output. The next En=1 edge reloads normally.
- No other state exists.

Optional Feature:
- Macro FFT1024_TWIDDLE_COMB_EN.
- When defined:
  - twiddle is a purely combinational function of n with zero latency.
  - Clk, Reset and En are ignored.
  - This matches the FFT core's same-cycle address/data usage.
- When undefined: the registered 1-cycle behaviour above applies.

Decomposition:
- Shared package fft1024_pkg holds:
  - localparams N=1024, LOG2N=10, TW_W=16, TW_SCALE=32767.
  - typedef twiddle_t, a packed struct of signed [15:0] re and signed [15:0] im.
- One natural sub-module, fft1024_quarter_sin_rom: combinational, input m[8:0], output q[14:0], 257 constant entries.
- The top level does quadrant decode, negation and the output register.

Test Plan:
- Reset asserted, then released with En=0 for 3 cycles → twiddle = 32'h0000_0000 throughout.
- En=1, n = 0, 256, 512, 768 on consecutive cycles → twiddle one cycle later = 32'h7FFF_0000, 32'h0000_8001, 32'h8001_0000, 32'h0000_7FFF.
- En=1, n=1 → 32'h7FFE_FF37 (re 32766, im −201). n=128 → 32'h5A82_A57E (re 23170, im −23170).
- Sweep all n = 0..1023 with En=1 → each output equals the rounded cos/−sin reference. Also check W^(n+512) = −W^n and re² + im² within ±2 LSB·32767 of 32767².
- Load n=128, then set En=0 and change n to 300 → output stays 32'h5A82_A57E. Assert Reset with En=1 → output becomes 0 on the next edge.
- With FFT1024_TWIDDLE_COMB_EN defined: n=256 → twiddle = 32'h0000_8001 in the same cycle, regardless of Clk, Reset and En.
